// File: rtl/dcache_pkg.sv
// Shared state encoding and address-field constants for the direct-mapped write-back D-cache.
// Module parameters override the defaults below; field LSBs are fixed by the core's address layout.
package dcache_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int NUM_BLOCKS_DEF = 8;
  localparam int ADDR_W_DEF     = 30;
  localparam int WORD_LSB       = 0;
  localparam int INDEX_LSB      = 2;
  localparam int INDEX_W        = $clog2(NUM_BLOCKS_DEF);
  localparam int TAG_W          = ADDR_W_DEF - 2 - INDEX_W;
  localparam int BLOCK_W        = 128;
endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data, one async read port, a full-line refill port and a word store port.
// Writes land on the rising edge; reads are combinational; no backpressure.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int TW         = TAG_W,
  parameter int IW         = $clog2(NUM_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IW-1:0]      rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TW-1:0]      rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               fill_en,
  input  logic [IW-1:0]      fill_idx,
  input  logic [TW-1:0]      fill_tag,
  input  logic [BLOCK_W-1:0] fill_data,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [1:0]         wr_word,
  input  logic [31:0]        wr_data,
  input  logic               clean_en,
  input  logic [IW-1:0]      clean_idx
);
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TW-1:0]         tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
        dirty[fill_idx] <= 1'b0;
        tag[fill_idx]   <= fill_tag;
        data[fill_idx]  <= fill_data;
      end
      if (clean_en)
        dirty[clean_idx] <= 1'b0;
      // Word store marks the line dirty; refill and store never coincide in the FSM.
      if (wr_en) begin
        data[wr_idx][{wr_word, 5'd0} +: 32] <= wr_data;
        dirty[wr_idx]                       <= 1'b1;
      end
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag[rd_idx];
  assign rd_data  = data[rd_idx];
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate D-cache: hits serve in 0 cycles, misses stall through writeback+refill.
// Core is stalled for the whole miss; memory side waits on a one-cycle mem_ready pulse per block transfer.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [31:0]        proc_wdata,
  output logic               proc_stall,
  output logic [31:0]        proc_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-3:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready
);
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int TW = ADDR_W - 2 - IW;

  state_t              state, state_nxt;
  logic [ADDR_W-3:0]   miss_blk;
  logic                miss_start;
  logic                req, hit;
  logic [IW-1:0]       req_idx, cur_idx;
  logic [1:0]          req_word;
  logic                rd_valid, rd_dirty;
  logic [TW-1:0]       rd_tag;
  logic [BLOCK_W-1:0]  rd_data;
  logic                fill_en, wr_en, clean_en;

  assign req      = proc_read | proc_write;
  assign req_idx  = proc_addr[INDEX_LSB +: IW];
  assign req_word = proc_addr[WORD_LSB +: 2];
  // Outside IDLE the line is addressed from the latched miss block, so a withdrawn request cannot redirect it.
  assign cur_idx  = (state == IDLE) ? req_idx : miss_blk[IW-1:0];
  assign hit      = req & rd_valid & (rd_tag == proc_addr[ADDR_W-1 -: TW]);

  dcache_line_array #(.NUM_BLOCKS(NUM_BLOCKS), .TW(TW), .IW(IW)) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (cur_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_idx  (miss_blk[IW-1:0]),
    .fill_tag  (miss_blk[ADDR_W-3 -: TW]),
    .fill_data (mem_rdata),
    .wr_en     (wr_en),
    .wr_idx    (req_idx),
    .wr_word   (req_word),
    .wr_data   (proc_wdata),
    .clean_en  (clean_en),
    .clean_idx (miss_blk[IW-1:0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      miss_blk <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start)
        miss_blk <= proc_addr[ADDR_W-1:2];
    end
  end

  always_comb begin
    state_nxt  = state;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_en    = 1'b0;
    wr_en      = 1'b0;
    clean_en   = 1'b0;
    miss_start = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // Simultaneous read+write is treated as a write.
            if (proc_write) wr_en = 1'b1;
            else            proc_rdata = rd_data[{req_word, 5'd0} +: 32];
          end else begin
            proc_stall = 1'b1;
            miss_start = 1'b1;
            state_nxt  = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {rd_tag, cur_idx};
        mem_wdata  = rd_data;
        if (mem_ready) begin
          clean_en  = 1'b1;
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = miss_blk;
        if (mem_ready) begin
          fill_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
